fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Generates the 2-bit select codes for the EX-stage operand Mux4s (fwd_a, fwd_b) and the load-use stall.
//  Keeps its own ID->EX->MEM->WB shadow pipeline of {valid, rd, regwrite, memread} per instruction.
//  Sits beside the 5-stage datapath: it produces the select codes that the operand muxes consume.
// PARAMETERS
//  RA_W   5   register-address width (x0..x31)
//  CNT_W  32  width of the stall performance counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  id_valid     in   1      ID stage holds a real instruction
//  id_rs1       in   RA_W   ID source register 1
//  id_rs2       in   RA_W   ID source register 2
//  id_rd        in   RA_W   ID destination register
//  id_regwrite  in   1      ID instruction writes rd
//  id_memread   in   1      ID instruction is a load
//  flush        in   1      branch/jump taken in EX; kill ID and EX entries
//  fwd_a        out  2      EX operand-A mux select
//  fwd_b        out  2      EX operand-B mux select
//  stall        out  1      hold PC and IF/ID; bubble into EX
//  stall_count  out  CNT_W  number of stall cycles since reset, saturating
// BEHAVIOUR
//  Select encoding: 00 = ID/EX register-file value; 01 = EX/MEM ALU result; 10 = MEM/WB write-back data.
//   Code 11 is never driven.
//  Shadow stages ex_*, mem_*, wb_* also hold ex_rs1/ex_rs2. On each clk the entries shift ID->EX->MEM->WB.
//   EX entry gets the ID inputs, or a bubble (valid=0) when stall or flush is 1.
//   flush also clears the captured ID entry; a flushed EX entry still advances to MEM as a bubble.
//  Forwarding (combinational from shadow regs, same cycle as EX):
//   fwd_a = 01 if mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1;
//   else 10 if wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1;
//   else 00. fwd_b is identical using ex_rs2. MEM beats WB when both match.
//  Load-use: stall = id_valid & ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//   rs2 is compared unconditionally; a false stall on I-type instructions is accepted.
//   The stall lasts exactly one cycle. Next cycle EX holds a bubble and the load is in MEM.
//   The held instruction is then served by fwd code 10 one cycle later.
//  flush has priority over stall: stall is forced to 0 when flush=1.
//  stall_count increments on every cycle with stall=1 and saturates at all-ones.
//  Reset (async, rst_n=0): all shadow valid bits=0, rd fields=0, stall_count=0.
//   Outputs are then fwd_a=fwd_b=00 and stall=0. Reset mid-stall drops the bubble and held state immediately.
//  x0 is never a forwarding or stall source.
// STRUCTURE
//  Shared package (cpu_pkg): RA_W, typedef fwd_sel_t with constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
//   The same package also holds typedef stage_tag_t {valid, rd, regwrite, memread}.
//  One sub-module: fwd_sel, a pure compare/priority block instantiated twice (operand A and operand B).
//  Shadow registers and the counter live in the top level. There is no other state.
// TESTING
//  1. x1=ALU in cycle n, next instruction reads rs1=x1 -> in the consumer's EX cycle fwd_a=01, fwd_b=00.
//  2. ALU writes x2; then 1 unrelated instruction; then a reader of rs2=x2 -> fwd_b=10.
//  3. Two back-to-back writers of x3, then a reader of x3 -> fwd_a=01 (MEM beats WB).
//  4. Load x5 followed immediately by a reader of x5 -> stall=1 for exactly 1 cycle, then EX bubble.
//     Next cycle fwd=10 and stall_count=1.
//  5. Load to x0, then a reader of x0; ALU writes to x0 -> stall=0 and fwd=00 throughout.
//  6. Load-use stall coincident with flush=1 -> stall=0 and EX bubble. Then assert rst_n=0 asynchronously mid-sequence.
//     Outputs must be 00/00/0 and stall_count=0 before the next clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-address width, operand-mux select codes,
// and the per-instruction tag carried by the hazard unit's shadow pipeline.
package cpu_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwrite;
        logic            memread;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select: picks the youngest in-flight producer of ex_rs.
// x0 is hardwired to zero, so it is never forwarded.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [RA_W-1:0] ex_rs,
    input  stage_tag_t      mem_tag,
    input  stage_tag_t      wb_tag,
    output fwd_sel_t        sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_tag.valid && mem_tag.regwrite &&
                     (mem_tag.rd != '0) && (mem_tag.rd == ex_rs);
    assign wb_hit  = wb_tag.valid && wb_tag.regwrite &&
                     (wb_tag.rd != '0) && (wb_tag.rd == ex_rs);

    // NOTE: every path assigns sel, so this stays combinational (no latch).
    always_comb begin
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with its own EX/MEM/WB shadow tags.
// Drives the EX operand-mux selects, the one-cycle load-use stall and a stall counter.
module fwd_hazard_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    stage_tag_t      ex_tag;
    stage_tag_t      mem_tag;
    stage_tag_t      wb_tag;
    stage_tag_t      id_tag;
    logic [RA_W-1:0] ex_rs1;
    logic [RA_W-1:0] ex_rs2;
    logic            load_use;
    fwd_sel_t        sel_a;
    fwd_sel_t        sel_b;

    assign id_tag = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

    // rs2 is compared even for I-type consumers; the occasional false stall is harmless.
    assign load_use = id_valid && ex_tag.valid && ex_tag.memread && (ex_tag.rd != '0) &&
                      ((ex_tag.rd == id_rs1) || (ex_tag.rd == id_rs2));
    assign stall    = load_use && !flush;

    // NOTE: state uses non-blocking assignments so every stage shifts off the same old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag  <= TAG_BUBBLE;
            mem_tag <= TAG_BUBBLE;
            wb_tag  <= TAG_BUBBLE;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
        end else begin
            wb_tag  <= mem_tag;
            mem_tag <= flush ? TAG_BUBBLE : ex_tag;
            // A bubble carries rs=x0, so nothing is ever forwarded into it.
            if (stall || flush) begin
                ex_tag <= TAG_BUBBLE;
                ex_rs1 <= '0;
                ex_rs2 <= '0;
            end else begin
                ex_tag <= id_tag;
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    fwd_sel u_fwd_a (
        .ex_rs   (ex_rs1),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (sel_a)
    );

    fwd_sel u_fwd_b (
        .ex_rs   (ex_rs2),
        .mem_tag (mem_tag),
        .wb_tag  (wb_tag),
        .sel     (sel_b)
    );

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed hazard scenarios, then random
// traffic, all compared against an instruction-level pipeline model.
module tb_fwd_hazard_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        stall;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .flush       (flush),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
        .stall_count (stall_count)
    );

    // Model: one record per in-flight instruction; index = stages past ID (0=EX, 1=MEM, 2=WB).
    typedef struct {
        bit          v;
        int unsigned rd;
        bit          rw;
        bit          ld;
        int unsigned rs1;
        int unsigned rs2;
    } instr_t;

    instr_t          pipe [3];
    instr_t          bub;
    longint unsigned m_count;
    int              checks = 0;
    int              failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The producer closest to EX wins; its distance from EX is the select code.
    function automatic int model_fwd(input int unsigned src);
        for (int age = 1; age <= 2; age++) begin
            if (pipe[age].v && pipe[age].rw && pipe[age].rd != 0 && pipe[age].rd == src)
                return age;
        end
        return 0;
    endfunction

    function automatic bit model_stall(input instr_t id, input bit fl);
        return !fl && id.v && pipe[0].v && pipe[0].ld && pipe[0].rd != 0 &&
               (pipe[0].rd == id.rs1 || pipe[0].rd == id.rs2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = bub;
        m_count = 0;
    endtask

    // One clock: drive ID at negedge, check before posedge, advance model at posedge.
    // Literal expectations of -1 are skipped.
    task automatic cycle(input string tag, input bit v, input int rs1, input int rs2,
                         input int rd, input bit rw, input bit ld, input bit fl,
                         input int ea = -1, input int eb = -1, input int es = -1,
                         input int ec = -1);
        instr_t id;
        bit     st;
        id = '{v: v, rd: rd, rw: rw, ld: ld, rs1: rs1, rs2: rs2};
        id_valid    = v;
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_rd       = 5'(rd);
        id_regwrite = rw;
        id_memread  = ld;
        flush       = fl;
        #1;
        st = model_stall(id, fl);
        chk({tag, "_fwd_a"}, 32'(fwd_a), 32'(model_fwd(pipe[0].rs1)));
        chk({tag, "_fwd_b"}, 32'(fwd_b), 32'(model_fwd(pipe[0].rs2)));
        chk({tag, "_stall"}, 32'(stall), 32'(st));
        chk({tag, "_count"}, stall_count, 32'(m_count));
        if (ea >= 0) chk({tag, "_lit_a"}, 32'(fwd_a), 32'(ea));
        if (eb >= 0) chk({tag, "_lit_b"}, 32'(fwd_b), 32'(eb));
        if (es >= 0) chk({tag, "_lit_stall"}, 32'(stall), 32'(es));
        if (ec >= 0) chk({tag, "_lit_count"}, stall_count, 32'(ec));
        @(posedge clk);
        if (st && m_count != 64'hFFFF_FFFF) m_count++;
        pipe[2] = pipe[1];
        pipe[1] = fl ? bub : pipe[0];
        pipe[0] = (st || fl) ? bub : id;
        @(negedge clk);
    endtask

    task automatic nop(input string tag, input int ea = -1, input int eb = -1,
                       input int es = -1, input int ec = -1);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, ea, eb, es, ec);
    endtask

    initial begin
        bub = '{v: 0, rd: 0, rw: 0, ld: 0, rs1: 0, rs2: 0};
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_fwd_a", 32'(fwd_a), 32'd0);
        chk("reset_fwd_b", 32'(fwd_b), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_count", stall_count, 32'd0);
        rst_n = 1'b1;

        // 1: EX/MEM forward to rs1
        cycle("t1_wr",   1, 0, 0, 1, 1, 0, 0);
        cycle("t1_rd",   1, 1, 6, 8, 0, 0, 0);
        nop("t1_chk", 1, 0);
        nop("t1_pad");
        nop("t1_pad2");

        // 2: MEM/WB forward to rs2 across one unrelated instruction
        cycle("t2_wr",   1, 0, 0, 2, 1, 0, 0);
        cycle("t2_mid",  1, 9, 10, 11, 1, 0, 0);
        cycle("t2_rd",   1, 12, 2, 14, 0, 0, 0);
        nop("t2_chk", 0, 2);
        nop("t2_pad");
        nop("t2_pad2");

        // 3: two writers of x3, MEM beats WB
        cycle("t3_wr0",  1, 0, 0, 3, 1, 0, 0);
        cycle("t3_wr1",  1, 0, 0, 3, 1, 0, 0);
        cycle("t3_rd",   1, 3, 3, 15, 0, 0, 0);
        nop("t3_chk", 1, 1);
        nop("t3_pad");
        nop("t3_pad2");

        // 4: load-use on x5: one stall, bubble, then MEM/WB forward
        cycle("t4_ld",   1, 0, 0, 5, 1, 1, 0, -1, -1, 0, 0);
        cycle("t4_use",  1, 5, 13, 16, 0, 0, 0, -1, -1, 1, 0);
        cycle("t4_held", 1, 5, 13, 16, 0, 0, 0, 0, 0, 0, 1);
        nop("t4_chk", 2, 0, 0, 1);
        nop("t4_pad");
        nop("t4_pad2");

        // 5: x0 is never a source
        cycle("t5_ld0",  1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        cycle("t5_use0", 1, 0, 0, 17, 0, 0, 0, 0, 0, 0);
        cycle("t5_alu0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle("t5_rd0",  1, 0, 0, 18, 0, 0, 0, 0, 0, 0);
        nop("t5_chk0", 0, 0, 0);
        nop("t5_chk1", 0, 0, 0, 1);
        nop("t5_pad");

        // 6: flush wins over load-use
        cycle("t6_ld",   1, 0, 0, 6, 1, 1, 0);
        cycle("t6_fl",   1, 6, 6, 19, 0, 0, 1, -1, -1, 0, 1);
        nop("t6_chk", 0, 0, 0, 1);
        nop("t6_pad");

        // Random traffic over a few registers to provoke frequent hazards
        for (int n = 0; n < 400; n++) begin
            cycle("rnd", $urandom_range(9, 0) < 8, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(2, 0) == 0,
                  $urandom_range(11, 0) == 0);
        end

        // Asynchronous reset asserted in the middle of a load-use stall
        cycle("ar_ld", 1, 0, 0, 7, 1, 1, 0);
        id_valid    = 1'b1;
        id_rs1      = 5'd7;
        id_rs2      = 5'd1;
        id_rd       = 5'd20;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
        flush       = 1'b0;
        #1;
        chk("ar_pre_stall", 32'(stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_fwd_a", 32'(fwd_a), 32'd0);
        chk("ar_fwd_b", 32'(fwd_b), 32'd0);
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_count", stall_count, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        nop("post_rst", 0, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            cycle("rnd2", $urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                  $urandom_range(15, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
